// File: rtl/pmod_stim_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pmod_stim_pkg
//  Purpose  : Shared types and constants for the pmod stimulus driver.
//             Holds the controller state encoding, the packed command and
//             response records and the pin-bus width.
//  Revision : 1.0  initial release
// ============================================================================
package pmod_stim_pkg;

  // Every pmod-facing bus (ui, uo, uio) is one byte wide.
  localparam int PIN_W = 8;

  // Widest hold count the command record can carry. The driver's HOLD_W
  // parameter must not exceed this.
  localparam int HOLD_W_MAX = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Command as held by the driver. While a transaction is in DRIVE the
  // hold field counts down the remaining drive cycles.
  typedef struct packed {
    logic [PIN_W-1:0]      ui;
    logic [PIN_W-1:0]      uio;
    logic [PIN_W-1:0]      uio_oe;
    logic [HOLD_W_MAX-1:0] hold;
  } cmd_t;

  typedef struct packed {
    logic [PIN_W-1:0] uo;
    logic [PIN_W-1:0] uio;
    logic [PIN_W-1:0] conflict;
  } rsp_t;

endpackage : pmod_stim_pkg
`default_nettype wire

// File: rtl/pin_sync.sv
`default_nettype none
// ============================================================================
//  Module   : pin_sync
//  Purpose  : Multi-flop synchroniser for asynchronous pin inputs. Each bit
//             passes through STAGES flops; all flops clear to 0 on rst.
//  Ports    : clk  - sampling clock
//             rst  - synchronous active-high reset
//             i_d  - asynchronous input bus
//             o_q  - synchronised output bus (STAGES cycles of latency)
//  Revision : 1.0  initial release
// ============================================================================
module pin_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        r_stage[s] <= '0;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int s = 1; s < STAGES; s++) begin
        r_stage[s] <= r_stage[s-1];
      end
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule : pin_sync
`default_nettype wire

// File: rtl/pmod_stim_driver.sv
`default_nettype none
// ============================================================================
//  Module   : pmod_stim_driver
//  Purpose  : Host-side initiator for the pmod pin interface. Accepts one
//             command, drives ui/uio pins for a programmable hold time,
//             waits for the synchronised pin readback to settle, then
//             returns one response with captured uo/uio and a per-bit uio
//             contention flag.
//  Ports    : clk, rst                  - clock, synchronous active-high reset
//             cmd_valid/cmd_ready       - command handshake
//             cmd_ui/cmd_uio/cmd_uio_oe - pin values and uio drive enables
//             cmd_hold                  - drive cycles (0 behaves as 1)
//             rsp_valid/rsp_ready       - response handshake
//             rsp_uo/rsp_uio            - captured project outputs
//             rsp_conflict              - driven uio bits read back wrong
//             pin_ui/pin_uio_out/oe     - pin drive towards the project
//             pin_uo_in/pin_uio_in      - asynchronous pin readback
//             busy                      - transaction in progress
//  Revision : 1.0  initial release
// ============================================================================
module pmod_stim_driver
  import pmod_stim_pkg::*;
#(
  parameter int HOLD_W      = 8,  // hold counter width, at most HOLD_W_MAX
  parameter int SYNC_STAGES = 2,  // synchroniser depth, at least 2
  parameter int SETTLE      = 2   // post-hold wait, at least SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [PIN_W-1:0]  cmd_ui,
  input  logic [PIN_W-1:0]  cmd_uio,
  input  logic [PIN_W-1:0]  cmd_uio_oe,
  input  logic [HOLD_W-1:0] cmd_hold,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [PIN_W-1:0]  rsp_uo,
  output logic [PIN_W-1:0]  rsp_uio,
  output logic [PIN_W-1:0]  rsp_conflict,
  output logic [PIN_W-1:0]  pin_ui,
  output logic [PIN_W-1:0]  pin_uio_out,
  output logic [PIN_W-1:0]  pin_uio_oe,
  input  logic [PIN_W-1:0]  pin_uo_in,
  input  logic [PIN_W-1:0]  pin_uio_in,
  output logic              busy
);

  localparam int c_SCNT_W = $clog2(SETTLE + 1);

  state_t               r_state;
  state_t               w_state_nxt;
  cmd_t                 r_cmd;
  cmd_t                 w_cmd_in;
  rsp_t                 r_rsp;
  logic [c_SCNT_W-1:0]  r_scnt;
  logic [HOLD_W-1:0]    w_hold_eff;
  logic [PIN_W-1:0]     w_sync_uo;
  logic [PIN_W-1:0]     w_sync_uio;

  logic w_cmd_ready;
  logic w_rsp_valid;
  logic w_busy;
  logic w_accept;
  logic w_drive_last;
  logic w_settle_last;
  logic w_rsp_hs;

  // --------------------------------------------------------------------------
  // Readback synchronisers: free-running, independent of the controller.
  // --------------------------------------------------------------------------
  pin_sync #(
    .WIDTH  (PIN_W),
    .STAGES (SYNC_STAGES)
  ) u_sync_uo (
    .clk (clk),
    .rst (rst),
    .i_d (pin_uo_in),
    .o_q (w_sync_uo)
  );

  pin_sync #(
    .WIDTH  (PIN_W),
    .STAGES (SYNC_STAGES)
  ) u_sync_uio (
    .clk (clk),
    .rst (rst),
    .i_d (pin_uio_in),
    .o_q (w_sync_uio)
  );

  // --------------------------------------------------------------------------
  // Incoming command, with a zero hold promoted to one drive cycle.
  // --------------------------------------------------------------------------
  assign w_hold_eff = (cmd_hold == '0) ? HOLD_W'(1) : cmd_hold;

  always_comb begin
    w_cmd_in        = '0;
    w_cmd_in.ui     = cmd_ui;
    w_cmd_in.uio    = cmd_uio;
    w_cmd_in.uio_oe = cmd_uio_oe;
    w_cmd_in.hold   = HOLD_W_MAX'(w_hold_eff);
  end

  // --------------------------------------------------------------------------
  // FSM process 1: state register.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM process 2: next-state logic.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept)      w_state_nxt = ST_DRIVE;
      ST_DRIVE:  if (w_drive_last)  w_state_nxt = ST_SETTLE;
      ST_SETTLE: if (w_settle_last) w_state_nxt = ST_RESP;
      ST_RESP:   if (w_rsp_hs)      w_state_nxt = ST_IDLE;
      default:                      w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM process 3: outputs and per-state strobes. Everything is gated off
  // while rst is high so cmd_ready and busy drop in the reset cycle itself.
  // --------------------------------------------------------------------------
  always_comb begin
    w_cmd_ready   = 1'b0;
    w_rsp_valid   = 1'b0;
    w_busy        = 1'b0;
    w_accept      = 1'b0;
    w_drive_last  = 1'b0;
    w_settle_last = 1'b0;
    w_rsp_hs      = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_IDLE: begin
          w_cmd_ready = 1'b1;
          w_accept    = cmd_valid;
        end
        ST_DRIVE: begin
          w_busy       = 1'b1;
          // Count holds the drive cycles still to go, including this one.
          w_drive_last = (r_cmd.hold <= HOLD_W_MAX'(1));
        end
        ST_SETTLE: begin
          w_busy        = 1'b1;
          w_settle_last = (r_scnt <= c_SCNT_W'(1));
        end
        ST_RESP: begin
          w_busy      = 1'b1;
          w_rsp_valid = 1'b1;
          w_rsp_hs    = rsp_ready;
        end
        default: begin
          w_busy = 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Datapath: pin drive, counters and response capture.
  // Pin drive is only rewritten on acceptance, so the last command's levels
  // stay on the pins between transactions.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd  <= '0;
      r_scnt <= '0;
      r_rsp  <= '0;
    end else begin
      if (w_accept) begin
        r_cmd <= w_cmd_in;
      end else if ((r_state == ST_DRIVE) && !w_drive_last) begin
        r_cmd.hold <= r_cmd.hold - HOLD_W_MAX'(1);
      end

      if (w_drive_last) begin
        r_scnt <= c_SCNT_W'(SETTLE);
      end else if ((r_state == ST_SETTLE) && !w_settle_last) begin
        r_scnt <= r_scnt - c_SCNT_W'(1);
      end

      if (w_settle_last) begin
        r_rsp.uo       <= w_sync_uo;
        r_rsp.uio      <= w_sync_uio;
        // A driven bit reading back at a different level means something
        // on the project side is fighting the driver.
        r_rsp.conflict <= r_cmd.uio_oe & (w_sync_uio ^ r_cmd.uio);
      end
    end
  end

  assign cmd_ready    = w_cmd_ready;
  assign rsp_valid    = w_rsp_valid;
  assign busy         = w_busy;
  assign rsp_uo       = r_rsp.uo;
  assign rsp_uio      = r_rsp.uio;
  assign rsp_conflict = r_rsp.conflict;
  assign pin_ui       = r_cmd.ui;
  assign pin_uio_out  = r_cmd.uio;
  assign pin_uio_oe   = r_cmd.uio_oe;

endmodule : pmod_stim_driver
`default_nettype wire

// File: tb/tb_pmod_stim_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pmod_stim_driver
//  Purpose  : Directed self-checking bench for pmod_stim_driver.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pmod_stim_driver;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_ui;
  logic [7:0] cmd_uio;
  logic [7:0] cmd_uio_oe;
  logic [7:0] cmd_hold;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_uo;
  logic [7:0] rsp_uio;
  logic [7:0] rsp_conflict;
  logic [7:0] pin_ui;
  logic [7:0] pin_uio_out;
  logic [7:0] pin_uio_oe;
  logic [7:0] pin_uo_in;
  logic [7:0] pin_uio_in;
  logic       busy;

  logic       loop_en;
  logic [7:0] tb_uo;
  logic [7:0] tb_uio;

  int checks;
  int errors;

  assign pin_uo_in  = loop_en ? pin_ui : tb_uo;
  assign pin_uio_in = tb_uio;

  pmod_stim_driver #(
    .HOLD_W      (8),
    .SYNC_STAGES (2),
    .SETTLE      (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_ui       (cmd_ui),
    .cmd_uio      (cmd_uio),
    .cmd_uio_oe   (cmd_uio_oe),
    .cmd_hold     (cmd_hold),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_uo       (rsp_uo),
    .rsp_uio      (rsp_uio),
    .rsp_conflict (rsp_conflict),
    .pin_ui       (pin_ui),
    .pin_uio_out  (pin_uio_out),
    .pin_uio_oe   (pin_uio_oe),
    .pin_uo_in    (pin_uo_in),
    .pin_uio_in   (pin_uio_in),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for cmd_ready, then presents one command for one edge.
  // On return the accept edge has just passed (cycle T+1).
  task automatic send(input logic [7:0] ui, input logic [7:0] uio,
                      input logic [7:0] oe, input logic [7:0] hold);
    int n = 0;
    while (!cmd_ready && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: cmd_ready=%b after %0d cycles, want 1", cmd_ready, n);
    end
    cmd_ui     = ui;
    cmd_uio    = uio;
    cmd_uio_oe = oe;
    cmd_hold   = hold;
    cmd_valid  = 1'b1;
    tick();
    cmd_valid  = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_rsp: rsp_valid=%b after %0d cycles, want 1", rsp_valid, n);
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    bit rdy_seen;
    rst = 1'b1;
    tick(); tick(); tick();
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready); end
    checks++; if (pin_ui !== 8'h00) begin errors++; $display("FAIL rst_pin_ui: got %h want 00", pin_ui); end
    checks++; if (pin_uio_oe !== 8'h00) begin errors++; $display("FAIL rst_uio_oe: got %h want 00", pin_uio_oe); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    rst = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", cmd_ready); end

    // Reset in the middle of a long DRIVE phase.
    send(8'hA5, 8'hA5, 8'hFF, 8'd10);
    tick(); tick();
    checks++; if (pin_ui !== 8'hA5) begin errors++; $display("FAIL mid_pin_ui: got %h want a5", pin_ui); end
    checks++; if (pin_uio_oe !== 8'hFF) begin errors++; $display("FAIL mid_uio_oe: got %h want ff", pin_uio_oe); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", busy); end
    rst = 1'b1;
    #1;
    rdy_seen = cmd_ready;
    tick();
    checks++; if (pin_ui !== 8'h00) begin errors++; $display("FAIL mid_rst_pin_ui: got %h want 00", pin_ui); end
    checks++; if ({pin_uio_oe, pin_uio_out} !== 16'h0000) begin errors++; $display("FAIL mid_rst_uio: got %h want 0000", {pin_uio_oe, pin_uio_out}); end
    checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL mid_rst_valid_busy: got %b want 00", {rsp_valid, busy}); end
    if (cmd_ready) rdy_seen = 1'b1;
    tick(); if (cmd_ready) rdy_seen = 1'b1;
    tick(); if (cmd_ready) rdy_seen = 1'b1;
    checks++; if (rdy_seen !== 1'b0) begin errors++; $display("FAIL mid_rst_ready_low: got %b want 0", rdy_seen); end
    rst = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready_after: got %b want 1", cmd_ready); end
    // No response may appear from the dropped transaction.
    for (int i = 0; i < 8; i++) tick();
    checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL mid_rst_no_rsp: got %b want 00", {rsp_valid, busy}); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_basic();
    bit rdy_bad;
    bit early;
    loop_en = 1'b1;
    send(8'h3C, 8'h00, 8'h00, 8'd4);
    checks++; if (pin_ui !== 8'h3C) begin errors++; $display("FAIL basic_pin_ui: got %h want 3c", pin_ui); end
    rdy_bad = cmd_ready;
    early   = rsp_valid;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (cmd_ready) rdy_bad = 1'b1;
      if (rsp_valid) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", early); end
    tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_t7: got %b want 1", rsp_valid); end
    checks++; if (rsp_uo !== 8'h3C) begin errors++; $display("FAIL basic_rsp_uo: got %h want 3c", rsp_uo); end
    checks++; if (rsp_conflict !== 8'h00) begin errors++; $display("FAIL basic_conflict: got %h want 00", rsp_conflict); end
    if (cmd_ready) rdy_bad = 1'b1;
    checks++; if (rdy_bad !== 1'b0) begin errors++; $display("FAIL basic_ready_low: got %b want 0", rdy_bad); end
    handshake();
    checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin errors++; $display("FAIL basic_after_hs: got %b want 01", {rsp_valid, cmd_ready}); end
    checks++; if (pin_ui !== 8'h3C) begin errors++; $display("FAIL basic_pin_persist: got %h want 3c", pin_ui); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_hold0();
    loop_en = 1'b1;
    send(8'h5A, 8'h00, 8'h00, 8'd0);
    tick(); tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL hold0_t3: got %b want 0", rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL hold0_t4: got %b want 1", rsp_valid); end
    checks++; if (rsp_uo !== 8'h5A) begin errors++; $display("FAIL hold0_rsp_uo: got %h want 5a", rsp_uo); end
    handshake();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_hold_max();
    loop_en = 1'b1;
    send(8'hC3, 8'h00, 8'h00, 8'd255);
    for (int i = 0; i < 256; i++) tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL holdmax_early: got %b want 0", rsp_valid); end
    tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL holdmax_valid: got %b want 1", rsp_valid); end
    checks++; if (rsp_uo !== 8'hC3) begin errors++; $display("FAIL holdmax_rsp_uo: got %h want c3", rsp_uo); end
    handshake();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_contention();
    loop_en = 1'b1;
    tb_uio  = 8'hF3;
    send(8'h00, 8'hF0, 8'hFF, 8'd2);
    checks++; if ({pin_uio_oe, pin_uio_out} !== 16'hFFF0) begin errors++; $display("FAIL cont_pins: got %h want fff0", {pin_uio_oe, pin_uio_out}); end
    wait_rsp();
    checks++; if (rsp_uio !== 8'hF3) begin errors++; $display("FAIL cont_rsp_uio: got %h want f3", rsp_uio); end
    checks++; if (rsp_conflict !== 8'h03) begin errors++; $display("FAIL cont_ff: got %h want 03", rsp_conflict); end
    handshake();
    send(8'h00, 8'hF0, 8'h0F, 8'd1);
    wait_rsp();
    checks++; if (rsp_conflict !== 8'h03) begin errors++; $display("FAIL cont_0f: got %h want 03", rsp_conflict); end
    handshake();
    send(8'h00, 8'hF0, 8'hF0, 8'd1);
    wait_rsp();
    checks++; if (rsp_conflict !== 8'h00) begin errors++; $display("FAIL cont_f0: got %h want 00", rsp_conflict); end
    checks++; if (rsp_uio !== 8'hF3) begin errors++; $display("FAIL cont_f0_uio: got %h want f3", rsp_uio); end
    handshake();
    tb_uio = 8'h00;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_backpressure();
    bit unstable;
    loop_en = 1'b0;
    tb_uo   = 8'h11;
    send(8'h22, 8'h00, 8'h00, 8'd1);
    wait_rsp();
    unstable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tb_uo     = ~tb_uo;
      cmd_ui    = 8'hEE;
      cmd_valid = (i % 2 == 0);
      tick();
      if (rsp_valid !== 1'b1 || rsp_uo !== 8'h11 || pin_ui !== 8'h22 || cmd_ready !== 1'b0)
        unstable = 1'b1;
    end
    cmd_valid = 1'b0;
    checks++; if (unstable !== 1'b0) begin errors++; $display("FAIL bp_stable: got %b want 0", unstable); end
    checks++; if (rsp_uo !== 8'h11) begin errors++; $display("FAIL bp_rsp_uo: got %h want 11", rsp_uo); end
    handshake();
    checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin errors++; $display("FAIL bp_after_hs: got %b want 01", {rsp_valid, cmd_ready}); end
    checks++; if (pin_ui !== 8'h22) begin errors++; $display("FAIL bp_pin_ui: got %h want 22", pin_ui); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_back_to_back();
    logic [7:0] vals [5];
    int nacc = 0;
    int nrsp = 0;
    int cyc  = 0;
    bit a;
    bit r;
    vals[0] = 8'h01; vals[1] = 8'h82; vals[2] = 8'h44; vals[3] = 8'h28; vals[4] = 8'h10;
    loop_en    = 1'b1;
    cmd_uio    = 8'h00;
    cmd_uio_oe = 8'h00;
    cmd_hold   = 8'd1;
    cmd_ui     = vals[0];
    cmd_valid  = 1'b1;
    rsp_ready  = 1'b1;
    while (nrsp < 5 && cyc < 300) begin
      a = cmd_valid && cmd_ready;
      r = rsp_valid && rsp_ready;
      if (r) begin
        checks++;
        if (rsp_uo !== vals[nrsp]) begin errors++; $display("FAIL b2b_rsp_uo[%0d]: got %h want %h", nrsp, rsp_uo, vals[nrsp]); end
        nrsp++;
      end
      if (a) begin
        checks++;
        if (nacc != nrsp) begin errors++; $display("FAIL b2b_overlap[%0d]: responses %0d want %0d", nacc, nrsp, nacc); end
        nacc++;
      end
      tick();
      cyc++;
      if (a) begin
        checks++;
        if (pin_ui !== vals[nacc-1]) begin errors++; $display("FAIL b2b_pin_ui[%0d]: got %h want %h", nacc-1, pin_ui, vals[nacc-1]); end
        if (nacc < 5) cmd_ui = vals[nacc];
        else cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    checks++; if (nrsp != 5 || nacc != 5) begin errors++; $display("FAIL b2b_count: got %0d/%0d want 5/5", nacc, nrsp); end
    tick(); tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_extra_rsp: got %b want 0", rsp_valid); end
  endtask

  // --------------------------------------------------------------------------
  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_ui     = 8'h00;
    cmd_uio    = 8'h00;
    cmd_uio_oe = 8'h00;
    cmd_hold   = 8'h00;
    rsp_ready  = 1'b0;
    loop_en    = 1'b1;
    tb_uo      = 8'h00;
    tb_uio     = 8'h00;

    test_reset();
    test_basic();
    test_hold0();
    test_hold_max();
    test_contention();
    test_backpressure();
    test_back_to_back();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_pmod_stim_driver
`default_nettype wire
